// File: rtl/fifo_gen_pkg.sv
// Shared definitions for fifo_gen: default geometry, depth helper and error-cause encodings.
// Build option: define FIFO_GEN_FWFT_EN for first-word-fall-through reads.
package fifo_gen_pkg;

  localparam int DEF_DATA_SIZE = 8;
  localparam int DEF_ADDR_SIZE = 2;

  // Error-cause encodings used when reporting overflow/underflow events
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  function automatic int cnt_size(input int addr_size);
    return addr_size + 1;
  endfunction

  function automatic int fifo_depth(input int addr_size);
    return 2 ** addr_size;
  endfunction

endpackage

// File: rtl/fifo_gen_ram.sv
// ram_dp_gen: simple dual-port RAM, synchronous write, read registered by default
// or combinational when FIFO_GEN_FWFT_EN is defined. No reset on storage.
module ram_dp_gen #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 2
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);

  logic [DATA_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef FIFO_GEN_FWFT_EN
  logic rd_en_unused;
  assign rd_en_unused = rd_en;
  assign rd_data      = mem[rd_addr];
`else
  // Read-first: a same-address write in the same cycle returns the old word
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/fifo_gen.sv
// fifo_gen: single-clock FIFO with programmable thresholds, hysteretic pause and sticky error.
// Build option: FIFO_GEN_FWFT_EN selects first-word-fall-through output.
module fifo_gen
  import fifo_gen_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int CNT_SIZE  = cnt_size(ADDR_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [CNT_SIZE-1:0]  af_thr,
  input  logic [CNT_SIZE-1:0]  ae_thr,
  input  logic                 err_clr,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 fifo_pause,
  output logic                 fifo_error,
  output logic [CNT_SIZE-1:0]  data_count
);

  localparam logic [CNT_SIZE-1:0] DEPTH = CNT_SIZE'(fifo_depth(ADDR_SIZE));

  logic [ADDR_SIZE-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_SIZE-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_SIZE-1:0]  count_reg, count_next;
  logic                 pause_reg, pause_next;
  logic                 error_reg, error_next;
  logic                 push_ok, pop_ok;
  logic [DATA_SIZE-1:0] rd_data;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == DEPTH);
  assign almost_full  = (count_reg >= af_thr);
  assign almost_empty = (count_reg != '0) && (count_reg <= ae_thr);
  assign data_count   = count_reg;
  assign fifo_pause   = pause_reg;
  assign fifo_error   = error_reg;

  // A full FIFO still accepts a push when the head is leaving in the same cycle
  assign push_ok = push && (!fifo_full || pop);
  assign pop_ok  = pop && !fifo_empty;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + ADDR_SIZE'(1);
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + ADDR_SIZE'(1);
    count_next = count_reg + CNT_SIZE'(push_ok) - CNT_SIZE'(pop_ok);

    // Set beats clear so a misprogrammed threshold pair fails safe (paused)
    pause_next = pause_reg;
    if (count_next >= af_thr)      pause_next = 1'b1;
    else if (count_next <= ae_thr) pause_next = 1'b0;

    error_next = error_reg;
    if ((push && fifo_full && !pop) || (pop && fifo_empty)) error_next = 1'b1;
    else if (err_clr)                                       error_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      pause_reg  <= 1'b0;
      error_reg  <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      pause_reg  <= pause_next;
      error_reg  <= error_next;
    end
  end

  ram_dp_gen #(
    .DATA_SIZE(DATA_SIZE),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk    (clk),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr_reg),
    .wr_data(data_in),
    .rd_en  (pop_ok),
    .rd_addr(rd_ptr_reg),
    .rd_data(rd_data)
  );

`ifdef FIFO_GEN_FWFT_EN
  assign data_out = rd_data;
`else
  // RAM output is unreset; mask it to zero until the first accepted pop
  logic out_valid_reg;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)    out_valid_reg <= 1'b0;
    else if (pop_ok) out_valid_reg <= 1'b1;
  end

  assign data_out = out_valid_reg ? rd_data : '0;
`endif

endmodule

// File: tb/tb_fifo_gen.sv
// Directed self-checking bench for fifo_gen (depth 4, af_thr=3, ae_thr=1), either read mode.
module tb_fifo_gen;
  import fifo_gen_pkg::*;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          push, pop, err_clr;
  logic [DW-1:0] data_in;
  logic [CW-1:0] af_thr, ae_thr;
  logic [DW-1:0] data_out;
  logic          fifo_empty, fifo_full, almost_full, almost_empty;
  logic          fifo_pause, fifo_error;
  logic [CW-1:0] data_count;

  int checks = 0;
  int errors = 0;

  fifo_gen #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .af_thr      (af_thr),
    .ae_thr      (ae_thr),
    .err_clr     (err_clr),
    .data_out    (data_out),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fifo_pause  (fifo_pause),
    .fifo_error  (fifo_error),
    .data_count  (data_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given controls; outputs are sampled 1ns after the edge
  task automatic op(input logic ps, input logic pp, input logic [DW-1:0] d, input logic clr);
    push = ps; pop = pp; data_in = d; err_clr = clr;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    $display("t=%0t push=%0b pop=%0b din=%02h clr=%0b -> cnt=%0d dout=%02h pause=%0b err=%0b",
             $time, ps, pp, d, clr, data_count, data_out, fifo_pause, fifo_error);
  endtask

  // Pop (optionally with a push) and check the popped word in either read mode
  task automatic pop_chk(input string tag, input logic ps, input logic [DW-1:0] d,
                         input logic [DW-1:0] exp);
`ifdef FIFO_GEN_FWFT_EN
    check(tag, data_out, exp);
    op(ps, 1'b1, d, 1'b0);
`else
    op(ps, 1'b1, d, 1'b0);
    check(tag, data_out, exp);
`endif
  endtask

  initial begin
    reset_L = 1'b0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    data_in = '0; af_thr = 3'd3; ae_thr = 3'd1;

    // Reset held for two clocks, released mid-cycle
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    #1;
    check("rst_count", data_count, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full",  fifo_full, 0);
    check("rst_af",    almost_full, 0);
    check("rst_ae",    almost_empty, 0);
    check("rst_pause", fifo_pause, 0);
    check("rst_error", fifo_error, 0);
`ifndef FIFO_GEN_FWFT_EN
    check("rst_dout",  data_out, 0);
`endif

    // Fill
    op(1, 0, 8'hA1, 0);
    check("fill1_count", data_count, 1);
    check("fill1_ae",    almost_empty, 1);
    check("fill1_pause", fifo_pause, 0);
`ifdef FIFO_GEN_FWFT_EN
    check("fill1_head",  data_out, 8'hA1);
`endif
    op(1, 0, 8'hA2, 0);
    check("fill2_ae",    almost_empty, 0);
    check("fill2_pause", fifo_pause, 0);
    op(1, 0, 8'hA3, 0);
    check("fill3_pause", fifo_pause, 1);
    check("fill3_af",    almost_full, 1);
    check("fill3_full",  fifo_full, 0);
    op(1, 0, 8'hA4, 0);
    check("fill4_count", data_count, 4);
    check("fill4_full",  fifo_full, 1);
    check("fill4_error", fifo_error, 0);

    // Overflow: rejected push, sticky error until cleared
    op(1, 0, 8'hA5, 0);
    $display("expected cause=%0b (overflow)", ERR_OVF);
    check("ovf_count", data_count, 4);
    check("ovf_error", fifo_error, 1);
    op(0, 0, 8'h00, 0);
    check("ovf_sticky", fifo_error, 1);
    op(0, 0, 8'h00, 1);
    check("ovf_clr", fifo_error, 0);

    // Push+pop while full
    pop_chk("full_pp_out", 1, 8'hB0, 8'hA1);
    check("full_pp_count", data_count, 4);
    check("full_pp_error", fifo_error, 0);

    // Drain; pause holds until count reaches ae_thr
    pop_chk("drain_a2", 0, 8'h00, 8'hA2);
    check("drain3_pause", fifo_pause, 1);
    pop_chk("drain_a3", 0, 8'h00, 8'hA3);
    check("drain2_pause", fifo_pause, 1);
    pop_chk("drain_a4", 0, 8'h00, 8'hA4);
    check("drain1_pause", fifo_pause, 0);
    pop_chk("drain_b0", 0, 8'h00, 8'hB0);
    check("drain_empty", fifo_empty, 1);
    check("drain_count", data_count, 0);

    // Underflow: rejected pop holds data_out and sets the error
    op(0, 1, 8'h00, 0);
    $display("expected cause=%0b (underflow)", ERR_UNF);
    check("unf_error", fifo_error, 1);
    check("unf_count", data_count, 0);
`ifndef FIFO_GEN_FWFT_EN
    check("unf_dout_hold", data_out, 8'hB0);
`endif
    // Error wins over a coincident clear
    op(0, 1, 8'h00, 1);
    check("unf_clr_lose", fifo_error, 1);
    op(0, 0, 8'h00, 1);
    check("unf_clr", fifo_error, 0);

    // Push+pop on empty: push accepted, pop flagged
    op(1, 1, 8'hC5, 0);
    check("empty_pp_count", data_count, 1);
    check("empty_pp_error", fifo_error, 1);
    op(0, 0, 8'h00, 1);
    pop_chk("empty_pp_out", 0, 8'h00, 8'hC5);

    // Wrap: interleaved push/pop across several pointer wraps
    for (int i = 0; i < 10; i++) begin
      op(1, 0, 8'(i), 0);
      pop_chk($sformatf("wrap_%0d", i), 0, 8'h00, 8'(i));
    end
    check("wrap_error", fifo_error, 0);
    check("wrap_empty", fifo_empty, 1);

    // Hysteresis: 2 <-> 3 keeps pause set; clears at 1
    op(1, 0, 8'h10, 0);
    op(1, 0, 8'h11, 0);
    check("hys2_pause", fifo_pause, 0);
    op(1, 0, 8'h12, 0);
    check("hys3_pause", fifo_pause, 1);
    pop_chk("hys_out10", 0, 8'h00, 8'h10);
    check("hys2b_pause", fifo_pause, 1);
    op(1, 0, 8'h13, 0);
    check("hys3b_pause", fifo_pause, 1);
    pop_chk("hys_out11", 0, 8'h00, 8'h11);
    check("hys2c_pause", fifo_pause, 1);
    pop_chk("hys_out12", 0, 8'h00, 8'h12);
    check("hys1_pause", fifo_pause, 0);
    pop_chk("hys_out13", 0, 8'h00, 8'h13);
    check("hys_empty", fifo_empty, 1);

    // Threshold extremes
    af_thr = 3'd0;
    op(0, 0, 8'h00, 0);
    check("af0_pause", fifo_pause, 1);
    af_thr = 3'd5;
    op(0, 0, 8'h00, 0);
    check("af5_pause", fifo_pause, 0);
    af_thr = 3'd3;

    // Asynchronous reset mid-transfer
    op(1, 0, 8'h77, 0);
    op(1, 0, 8'h78, 0);
    #2;
    reset_L = 1'b0;
    #1;
    check("areset_count", data_count, 0);
    check("areset_empty", fifo_empty, 1);
    @(negedge clk);
    reset_L = 1'b1;
    op(1, 0, 8'h99, 0);
    check("post_rst_count", data_count, 1);
    pop_chk("post_rst_out", 0, 8'h00, 8'h99);
    check("post_rst_error", fifo_error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
